mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access sequencer between EX/MEM and a
// single-port synchronous RAM. Splits misaligned loads/stores across two
// words, extends load results and stalls the pipeline while busy.
module mem_access_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_AW     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_func3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [3:0]            ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR2, DONE} state_t;

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   w_q;
  logic [1:0]          o_q;
  logic [2:0]          f3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [RAM_AW-1:0]   cur_w, w_next;
  logic [1:0]          cur_o;
  logic [2:0]          cur_f3;
  logic [DATA_W-1:0]   cur_wdata;
  logic [3:0]          size_c;
  logic [3:0]          mask_c;
  logic                split_c;
  logic [4:0]          shamt;
  logic [7:0]          be8;
  logic [2*DATA_W-1:0] wd2;
  logic [DATA_W-1:0]   lo_src;
  logic [DATA_W-1:0]   rd_cat;
  logic                illegal_c;

  logic                stall_c, rd_valid_c, err_c, ram_en_c, ram_we_c;
  logic [RAM_AW-1:0]   ram_addr_c;
  logic [3:0]          ram_be_c;
  logic [DATA_W-1:0]   ram_wdata_c;

  // Sign/zero extension of the extracted load value by access type
  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3,
                                               input logic [DATA_W-1:0] v);
    case (f3)
      3'b000:  return {{(DATA_W-8){v[7]}}, v[7:0]};
      3'b001:  return {{(DATA_W-16){v[15]}}, v[15:0]};
      3'b100:  return DATA_W'(v[7:0]);
      3'b101:  return DATA_W'(v[15:0]);
      default: return v;
    endcase
  endfunction

  // Current request: live inputs in IDLE, the captured copy afterwards
  always_comb begin
    if (state_q == IDLE) begin
      cur_w     = RAM_AW'(req_addr >> 2);
      cur_o     = req_addr[1:0];
      cur_f3    = req_func3;
      cur_wdata = req_wdata;
    end else begin
      cur_w     = w_q;
      cur_o     = o_q;
      cur_f3    = f3_q;
      cur_wdata = wdata_q;
    end
  end

  // Access size, lane mask, split detection and lane alignment
  always_comb begin
    case (cur_f3[1:0])
      2'b00:   begin size_c = 4'd1; mask_c = 4'b0001; end
      2'b01:   begin size_c = 4'd2; mask_c = 4'b0011; end
      default: begin size_c = 4'd4; mask_c = 4'b1111; end
    endcase
    split_c = (4'({2'b00, cur_o}) + size_c) > 4'd4;
    shamt   = {cur_o, 3'b000};
    w_next  = cur_w + RAM_AW'(1);
    be8     = {4'b0000, mask_c} << cur_o;
    wd2     = {{DATA_W{1'b0}}, cur_wdata} << shamt;
    lo_src  = (state_q == RD2) ? lo_q : ram_rdata;
    rd_cat  = DATA_W'({ram_rdata, lo_src} >> shamt);
  end

  // Illegal request decode (only meaningful in IDLE)
  always_comb begin
    illegal_c = (req_rd && req_wr) ||
                ((req_rd || req_wr) && (req_func3 == 3'b011 || req_func3[2:1] == 2'b11)) ||
                (req_wr && req_func3[2]);
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    rd_valid_c  = 1'b0;
    err_c       = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_be_c    = 4'b0000;
    ram_wdata_c = '0;
    rd_data_d   = rd_data_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (illegal_c) begin
          err_c = 1'b1;
        end else if (req_rd) begin
          ram_en_c   = 1'b1;
          ram_addr_c = cur_w;
          stall_c    = 1'b1;
          state_d    = RD1;
        end else if (req_wr) begin
          ram_en_c    = 1'b1;
          ram_we_c    = 1'b1;
          ram_addr_c  = cur_w;
          ram_be_c    = be8[3:0];
          ram_wdata_c = wd2[DATA_W-1:0];
          if (split_c) begin
            stall_c = 1'b1;
            state_d = WR2;
          end
        end
      end
      RD1: begin
        stall_c = 1'b1;
        lo_d    = ram_rdata;
        if (split_c) begin
          ram_en_c   = 1'b1;
          ram_addr_c = w_next;
          state_d    = RD2;
        end else begin
          rd_data_d = extend(cur_f3, rd_cat);
          state_d   = DONE;
        end
      end
      RD2: begin
        stall_c   = 1'b1;
        rd_data_d = extend(cur_f3, rd_cat);
        state_d   = DONE;
      end
      WR2: begin
        ram_en_c    = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = w_next;
        ram_be_c    = be8[7:4];
        ram_wdata_c = wd2[2*DATA_W-1:DATA_W];
        state_d     = IDLE;
      end
      DONE: begin
        rd_valid_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request capture and load result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      o_q       <= 2'b00;
      f3_q      <= 3'b000;
      wdata_q   <= '0;
      lo_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      rd_data_q <= rd_data_d;
      if (state_q == IDLE) begin
        w_q     <= cur_w;
        o_q     <= cur_o;
        f3_q    <= cur_f3;
        wdata_q <= cur_wdata;
      end
    end
  end

  // Outputs forced quiet while reset is asserted, so an abort is immediate
  assign stall     = reset & stall_c;
  assign rd_valid  = reset & rd_valid_c;
  assign err       = reset & err_c;
  assign ram_en    = reset & ram_en_c;
  assign ram_we    = reset & ram_we_c;
  assign ram_be    = reset ? ram_be_c    : 4'b0000;
  assign ram_addr  = reset ? ram_addr_c  : '0;
  assign ram_wdata = reset ? ram_wdata_c : '0;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven vectors plus hand-written corner
// sequences for mem_access_unit, with a load-result scoreboard queue.
module tb_mem_access_unit;

  localparam int unsigned DM_ADDRESS = 9;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RAM_AW     = 7;

  logic                  clk;
  logic                  reset;
  logic                  req_rd, req_wr;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_func3;
  logic                  stall, rd_valid, err, ram_en, ram_we;
  logic [DATA_W-1:0]     rd_data, ram_wdata, ram_rdata;
  logic [RAM_AW-1:0]     ram_addr;
  logic [3:0]            ram_be;

  logic [DATA_W-1:0]     mem [0:127];
  logic                  poke_en;
  logic [RAM_AW-1:0]     poke_idx;
  logic [DATA_W-1:0]     poke_val;

  logic [DATA_W-1:0]     sb [$];
  int                    total = 0;
  int                    bad   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          stalls;
    logic        err;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  mem_access_unit #(
    .DM_ADDRESS(DM_ADDRESS),
    .DATA_W    (DATA_W),
    .RAM_AW    (RAM_AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_func3(req_func3),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_be   (ram_be),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM with byte-lane writes and a bench preload port
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    if (ram_en && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [8:0] addr,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic [31:0] exp, input int stalls, input logic e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.f3 = f3; v.wdata = wd;
    v.exp = exp; v.stalls = stalls; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any load result there
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rd_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_valid_spurious got=1 want=0");
      end else begin
        e = sb.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data got=%h want=%h", rd_data, e);
        end
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [RAM_AW-1:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    sync();
    poke_en = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wd; req_func3 = f3;
  endtask

  // Present a request, hold it while stalled, report stall count and first-cycle flags
  task automatic issue(input logic rd, input logic wr, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output int stalls, output logic err_first, output logic en_first);
    bit done;
    drive(rd, wr, addr, wd, f3);
    stalls = 0; done = 0; err_first = 1'bx; en_first = 1'bx;
    for (int c = 0; c < 12 && !done; c++) begin
      tick();
      if (c == 0) begin err_first = err; en_first = ram_en; end
      if (stall) stalls++;
      else done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL stall_timeout got=stuck want=release");
    end
    sync();
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  initial begin
    int   st;
    logic ef, enf;

    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 9'h014, 32'h0, 3'b010);

    // Reset: outputs quiet even with a request presented
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({stall, rd_valid, err, ram_en, ram_we, ram_be}), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_rdata", rd_data, 32'h0);
    req_rd = 1'b0;
    reset  = 1'b1;
    sync();

    poke(7'd5, 32'hDEADBEEF);
    poke(7'd0, 32'h0000_80FF);
    poke(7'd1, 32'h8765_4321);
    poke(7'd2, 32'hAABB_CCDD);
    poke(7'd3, 32'h1122_3344);
    poke(7'd4, 32'h5566_7788);

    tbl[0]  = mk(1, 0, 9'h014, 3'b010, 32'h0, 32'hDEADBEEF, 2, 0);
    tbl[1]  = mk(1, 0, 9'h001, 3'b000, 32'h0, 32'hFFFFFF80, 2, 0);
    tbl[2]  = mk(1, 0, 9'h001, 3'b100, 32'h0, 32'h00000080, 2, 0);
    tbl[3]  = mk(1, 0, 9'h006, 3'b001, 32'h0, 32'hFFFF8765, 2, 0);
    tbl[4]  = mk(1, 0, 9'h006, 3'b101, 32'h0, 32'h00008765, 2, 0);
    tbl[5]  = mk(1, 0, 9'h00B, 3'b010, 32'h0, 32'h223344AA, 3, 0);
    tbl[6]  = mk(1, 0, 9'h00F, 3'b001, 32'h0, 32'hFFFF8811, 3, 0);
    tbl[7]  = mk(1, 0, 9'h00B, 3'b000, 32'h0, 32'hFFFFFFAA, 2, 0);
    tbl[8]  = mk(1, 0, 9'h00A, 3'b101, 32'h0, 32'h0000AABB, 2, 0);
    tbl[9]  = mk(1, 0, 9'h001, 3'b010, 32'h0, 32'h21000080, 3, 0);
    tbl[10] = mk(1, 1, 9'h014, 3'b010, 32'h0, 32'h0, 0, 1);
    tbl[11] = mk(1, 0, 9'h014, 3'b011, 32'h0, 32'h0, 0, 1);
    tbl[12] = mk(1, 0, 9'h014, 3'b110, 32'h0, 32'h0, 0, 1);
    tbl[13] = mk(0, 1, 9'h014, 3'b100, 32'h12345678, 32'h0, 0, 1);
    tbl[14] = mk(0, 1, 9'h014, 3'b111, 32'h12345678, 32'h0, 0, 1);
    tbl[15] = mk(0, 1, 9'h040, 3'b010, 32'h0BADCAFE, 32'h0, 0, 0);
    tbl[16] = mk(1, 0, 9'h040, 3'b010, 32'h0, 32'h0BADCAFE, 2, 0);
    tbl[17] = mk(0, 1, 9'h043, 3'b001, 32'h0000BEEF, 32'h0, 1, 0);
    tbl[18] = mk(1, 0, 9'h043, 3'b101, 32'h0, 32'h0000BEEF, 3, 0);
    tbl[19] = mk(1, 0, 9'h040, 3'b010, 32'h0, 32'hEFADCAFE, 2, 0);
    tbl[20] = mk(1, 0, 9'h014, 3'b010, 32'h0, 32'hDEADBEEF, 2, 0);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rd && !tbl[i].wr && !tbl[i].err) sb.push_back(tbl[i].exp);
      issue(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].f3, st, ef, enf);
      chk($sformatf("v%0d_stall", i), 32'(st), 32'(tbl[i].stalls));
      chk($sformatf("v%0d_err", i), 32'(ef), 32'(tbl[i].err));
      chk($sformatf("v%0d_en", i), 32'(enf), 32'(!tbl[i].err));
    end

    // Split SW across words 3/4, checked cycle by cycle
    drive(1'b0, 1'b1, 9'h00E, 32'h11223344, 3'b010);
    tick();
    chk("ssw1_enwe", 32'({ram_en, ram_we, stall}), 32'h7);
    chk("ssw1_addr", 32'(ram_addr), 32'd3);
    chk("ssw1_be", 32'(ram_be), 32'hC);
    chk("ssw1_data", ram_wdata, 32'h3344_0000);
    tick();
    chk("ssw2_enwe", 32'({ram_en, ram_we, stall}), 32'h6);
    chk("ssw2_addr", 32'(ram_addr), 32'd4);
    chk("ssw2_be", 32'(ram_be), 32'h3);
    chk("ssw2_data", ram_wdata, 32'h0000_1122);
    sync();
    req_wr = 1'b0;
    tick();
    chk("idle_we_be", 32'({ram_we, ram_be}), 32'h0);
    sync();
    sb.push_back(32'h11223344);
    issue(1'b1, 1'b0, 9'h00E, 32'h0, 3'b010, st, ef, enf);
    chk("ssw_rb_stall", 32'(st), 32'd3);

    // Aligned SB into lane 1
    drive(1'b0, 1'b1, 9'h021, 32'h0000_00A5, 3'b000);
    tick();
    chk("sb_be", 32'(ram_be), 32'h2);
    chk("sb_data", ram_wdata, 32'h0000_A500);
    chk("sb_addr_stall", 32'({ram_addr, stall}), 32'({7'd8, 1'b0}));
    sync();
    req_wr = 1'b0;
    sb.push_back(32'h0000_00A5);
    issue(1'b1, 1'b0, 9'h021, 32'h0, 3'b100, st, ef, enf);

    // Wrap-around LH from word 127 into word 0
    poke(7'd127, 32'hAB00_0000);
    poke(7'd0, 32'h0000_00CD);
    sb.push_back(32'hFFFF_CDAB);
    drive(1'b1, 1'b0, 9'h1FF, 32'h0, 3'b001);
    tick();
    chk("wrap_addr1", 32'(ram_addr), 32'd127);
    tick();
    chk("wrap_addr2", 32'({ram_en, ram_addr}), 32'({1'b1, 7'd0}));
    tick();
    chk("wrap_rd2_stall", 32'(stall), 32'd1);
    tick();
    chk("wrap_done_stall", 32'({stall, rd_valid}), 32'h1);
    sync();
    req_rd = 1'b0;

    // Reset asserted during the second half of a split store
    poke(7'd11, 32'h0);
    poke(7'd12, 32'h0);
    drive(1'b0, 1'b1, 9'h02E, 32'hCAFEF00D, 3'b010);
    tick();
    chk("wr2rst_first", 32'({stall, ram_be}), 32'h1C);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("wr2rst_ctrl", 32'({stall, rd_valid, err, ram_en, ram_we, ram_be}), 32'h0);
    chk("wr2rst_addr", 32'(ram_addr), 32'h0);
    chk("wr2rst_wdata", ram_wdata, 32'h0);
    chk("wr2rst_rdata", rd_data, 32'h0);
    req_wr = 1'b0;
    tick();
    reset = 1'b1;
    sync();
    sync();
    chk("wr2rst_mem12", mem[12], 32'h0);
    chk("wr2rst_mem11", mem[11], 32'hF00D_0000);
    sb.push_back(32'hF00D_0000);
    issue(1'b1, 1'b0, 9'h02C, 32'h0, 3'b010, st, ef, enf);
    chk("wr2rst_idle", 32'(st), 32'd2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
